// File: rtl/btn_script_pkg.sv
// Shared types for the button script player: FSM states, the default command
// record and the index-width helper.
package btn_script_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_GAP,
    ST_PRESS,
    ST_RELEASE
  } state_t;

  // Index width that stays legal for one- and two-button builds.
  function automatic int btn_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_BTNS = 5;
  localparam int DEF_TIME_W   = 16;
  localparam int DEF_TIMES_W  = 8;
  localparam int DEF_BTN_W    = btn_idx_w(DEF_NUM_BTNS);

  typedef struct packed {
    logic [DEF_BTN_W-1:0]   btn;
    logic [DEF_TIME_W-1:0]  pre_wait;
    logic [DEF_TIME_W-1:0]  up_time;
    logic [DEF_TIME_W-1:0]  down_time;
    logic [DEF_TIMES_W-1:0] times;
`ifdef BTN_SCRIPT_VSYNC_EN
    logic                   sync;
`endif
  } btn_cmd_t;

endpackage

// File: rtl/btn_script_player_if.sv
// Command push port of the button script player (valid/ready plus fields).
// BTN_SCRIPT_VSYNC_EN adds the i_cmd_sync field.
interface btn_script_player_if
  import btn_script_pkg::*;
#(
  parameter int NUM_BTNS = 5,
  parameter int TIME_W   = 16,
  parameter int TIMES_W  = 8
) ();

  localparam int BTN_W = btn_idx_w(NUM_BTNS);

  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [BTN_W-1:0]   i_cmd_btn;
  logic [TIME_W-1:0]  i_cmd_pre_wait;
  logic [TIME_W-1:0]  i_cmd_up_time;
  logic [TIME_W-1:0]  i_cmd_down_time;
  logic [TIMES_W-1:0] i_cmd_times;
`ifdef BTN_SCRIPT_VSYNC_EN
  logic               i_cmd_sync;
`endif

  modport master (
    output i_cmd_valid, i_cmd_btn, i_cmd_pre_wait, i_cmd_up_time,
           i_cmd_down_time, i_cmd_times,
`ifdef BTN_SCRIPT_VSYNC_EN
    output i_cmd_sync,
`endif
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd_btn, i_cmd_pre_wait, i_cmd_up_time,
           i_cmd_down_time, i_cmd_times,
`ifdef BTN_SCRIPT_VSYNC_EN
    input  i_cmd_sync,
`endif
    output o_cmd_ready
  );

endinterface

// File: rtl/btn_script_player_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; entry type is a parameter.
// Full pushes and empty pops are dropped.
module cmd_fifo
  import btn_script_pkg::*;
#(
  parameter type T     = btn_cmd_t,
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/btn_script_player.sv
// Scripted button-press sequencer: queued commands replayed as one-hot levels.
// BTN_SCRIPT_VSYNC_EN adds i_vsync and a per-command wait for its falling edge.
module btn_script_player
  import btn_script_pkg::*;
#(
  parameter int NUM_BTNS = 5,
  parameter int DEPTH    = 8,
  parameter int TIME_W   = 16,
  parameter int TIMES_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  btn_script_player_if.slave     cmd,
`ifdef BTN_SCRIPT_VSYNC_EN
  input  logic                   i_vsync,
`endif
  output logic [NUM_BTNS-1:0]    o_btns,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_err
);

  localparam int                 BTN_W     = btn_idx_w(NUM_BTNS);
  localparam logic [BTN_W:0]     BTN_LIMIT = (BTN_W + 1)'(NUM_BTNS);
  localparam logic [TIME_W-1:0]  TIME_ONE  = TIME_W'(1);
  localparam logic [TIMES_W-1:0] TIMES_ONE = TIMES_W'(1);

  typedef struct packed {
    logic [BTN_W-1:0]   btn;
    logic [TIME_W-1:0]  pre_wait;
    logic [TIME_W-1:0]  up_time;
    logic [TIME_W-1:0]  down_time;
    logic [TIMES_W-1:0] times;
`ifdef BTN_SCRIPT_VSYNC_EN
    logic               sync;
`endif
  } cmd_t;

  function automatic logic [NUM_BTNS-1:0] btn_mask(input logic [BTN_W-1:0] b);
    btn_mask = '0;
    if ({1'b0, b} < BTN_LIMIT) btn_mask[b] = 1'b1;
  endfunction

  // A zero press length still produces a one-cycle press.
  function automatic logic [TIME_W-1:0] press_cnt(input logic [TIME_W-1:0] up);
    return (up == '0) ? '0 : up - TIME_ONE;
  endfunction

  state_t             state;
  cmd_t               in_cmd, head, wcmd, src;
  logic [TIME_W-1:0]  cnt;
  logic [TIMES_W-1:0] rep;
  logic               fifo_full, fifo_empty, pop, start_sync;
  state_t             launch_state;
  logic [TIME_W-1:0]  launch_cnt;
  logic [NUM_BTNS-1:0] launch_btns;

  always_comb begin
    in_cmd.btn       = cmd.i_cmd_btn;
    in_cmd.pre_wait  = cmd.i_cmd_pre_wait;
    in_cmd.up_time   = cmd.i_cmd_up_time;
    in_cmd.down_time = cmd.i_cmd_down_time;
    in_cmd.times     = cmd.i_cmd_times;
`ifdef BTN_SCRIPT_VSYNC_EN
    in_cmd.sync      = cmd.i_cmd_sync;
`endif
  end

  assign pop             = (state == ST_IDLE) && !fifo_empty;
  assign cmd.o_cmd_ready = !fifo_full;
  assign o_busy          = (state != ST_IDLE) || (o_level != '0);

  cmd_fifo #(.T(cmd_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.i_cmd_valid),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

`ifdef BTN_SCRIPT_VSYNC_EN
  logic vs_meta, vs_sync, vs_prev, vs_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= i_vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_fall    = vs_prev && !vs_sync;
  assign start_sync = head.sync;
`else
  assign start_sync = 1'b0;
`endif

  // Where a freshly started command goes once any vsync wait is over.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    src          = (state == ST_IDLE) ? head : wcmd;
    launch_state = ST_IDLE;
    launch_cnt   = '0;
    launch_btns  = '0;
    if (src.pre_wait != '0) begin
      launch_state = ST_GAP;
      launch_cnt   = src.pre_wait - TIME_ONE;
    end else if (src.times != '0) begin
      launch_state = ST_PRESS;
      launch_cnt   = press_cnt(src.up_time);
      launch_btns  = btn_mask(src.btn);
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rep    <= '0;
      wcmd   <= '0;
      o_btns <= '0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            wcmd <= head;
            rep  <= head.times;
            if ({1'b0, head.btn} >= BTN_LIMIT) o_err <= 1'b1;
            if (start_sync) begin
              state <= ST_WAIT_VS;
            end else begin
              state  <= launch_state;
              cnt    <= launch_cnt;
              o_btns <= launch_btns;
              o_done <= (launch_state == ST_IDLE);
            end
          end
        end
`ifdef BTN_SCRIPT_VSYNC_EN
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state  <= launch_state;
            cnt    <= launch_cnt;
            o_btns <= launch_btns;
            o_done <= (launch_state == ST_IDLE);
          end
        end
`endif
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - TIME_ONE;
          end else if (rep != '0) begin
            state  <= ST_PRESS;
            cnt    <= press_cnt(wcmd.up_time);
            o_btns <= btn_mask(wcmd.btn);
          end else begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
          end
        end
        ST_PRESS, ST_RELEASE: begin
          if (cnt != '0) begin
            cnt <= cnt - TIME_ONE;
          end else if (state == ST_PRESS && wcmd.down_time != '0) begin
            state  <= ST_RELEASE;
            cnt    <= wcmd.down_time - TIME_ONE;
            o_btns <= '0;
          end else begin
            // Repeat check: rep counts the pairs still owed, including this one.
            rep <= rep - TIMES_ONE;
            if (rep != TIMES_ONE) begin
              state  <= ST_PRESS;
              cnt    <= press_cnt(wcmd.up_time);
              o_btns <= btn_mask(wcmd.btn);
            end else begin
              state  <= ST_IDLE;
              o_btns <= '0;
              o_done <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_btns <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_script_player.sv
// Self-checking bench for btn_script_player: command scripts are expanded into
// an expected per-cycle button/done trace and compared sample by sample.
module tb_btn_script_player;
  import btn_script_pkg::*;

  localparam int NUM_BTNS = 5;
  localparam int DEPTH    = 8;
  localparam int TIME_W   = 16;
  localparam int TIMES_W  = 8;
  localparam int BTN_W    = btn_idx_w(NUM_BTNS);

  typedef struct {
    int btn;
    int pre;
    int up;
    int down;
    int times;
  } tcmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_BTNS-1:0]    btns;
  logic                   busy, done, err;
  logic [$clog2(DEPTH):0] level;
`ifdef BTN_SCRIPT_VSYNC_EN
  logic vsync = 1'b1;
`endif

  btn_script_player_if #(.NUM_BTNS(NUM_BTNS), .TIME_W(TIME_W), .TIMES_W(TIMES_W)) cmd_if ();

  btn_script_player #(
    .NUM_BTNS(NUM_BTNS), .DEPTH(DEPTH), .TIME_W(TIME_W), .TIMES_W(TIMES_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd_if),
`ifdef BTN_SCRIPT_VSYNC_EN
    .i_vsync (vsync),
`endif
    .o_btns  (btns),
    .o_busy  (busy),
    .o_done  (done),
    .o_level (level),
    .o_err   (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit err_exp = 1'b0;

  function automatic tcmd_t mk(int btn, int pre, int up, int down, int times);
    tcmd_t c;
    c.btn = btn; c.pre = pre; c.up = up; c.down = down; c.times = times;
    return c;
  endfunction

  task automatic drive_idle();
    cmd_if.i_cmd_valid     = 1'b0;
    cmd_if.i_cmd_btn       = '0;
    cmd_if.i_cmd_pre_wait  = '0;
    cmd_if.i_cmd_up_time   = '0;
    cmd_if.i_cmd_down_time = '0;
    cmd_if.i_cmd_times     = '0;
`ifdef BTN_SCRIPT_VSYNC_EN
    cmd_if.i_cmd_sync      = 1'b0;
`endif
  endtask

  task automatic set_cmd(input tcmd_t c);
    cmd_if.i_cmd_valid     = 1'b1;
    cmd_if.i_cmd_btn       = BTN_W'(c.btn);
    cmd_if.i_cmd_pre_wait  = TIME_W'(c.pre);
    cmd_if.i_cmd_up_time   = TIME_W'(c.up);
    cmd_if.i_cmd_down_time = TIME_W'(c.down);
    cmd_if.i_cmd_times     = TIMES_W'(c.times);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: each command contributes pre idle samples, then times x
  // (max(up,1) pressed + down released), then one done sample in IDLE.
  task automatic run_script(input string name, input tcmd_t cmds[$]);
    logic [NUM_BTNS-1:0] exp_btn[$];
    bit                  exp_done[$];
    logic [NUM_BTNS-1:0] mask;
    exp_btn.push_back('0);
    exp_done.push_back(1'b0);
    foreach (cmds[k]) begin
      mask = '0;
      if (cmds[k].btn < NUM_BTNS) mask[cmds[k].btn] = 1'b1;
      else err_exp = 1'b1;
      repeat (cmds[k].pre) begin exp_btn.push_back('0); exp_done.push_back(1'b0); end
      repeat (cmds[k].times) begin
        repeat ((cmds[k].up == 0) ? 1 : cmds[k].up) begin
          exp_btn.push_back(mask); exp_done.push_back(1'b0);
        end
        repeat (cmds[k].down) begin exp_btn.push_back('0); exp_done.push_back(1'b0); end
      end
      exp_btn.push_back('0);
      exp_done.push_back(1'b1);
    end
    repeat (3) begin exp_btn.push_back('0); exp_done.push_back(1'b0); end

    for (int i = 0; i < exp_btn.size(); i++) begin
      if (i < cmds.size()) set_cmd(cmds[i]);
      else drive_idle();
      tick();
      n_tests++;
      if (btns !== exp_btn[i] || done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL %s sample %0d: btns=%b done=%b, expected btns=%b done=%b",
                 name, i, btns, done, exp_btn[i], exp_done[i]);
      end
    end
    drive_idle();
    n_tests++;
    if (busy !== 1'b0 || level !== '0 || err !== err_exp) begin
      n_fail++;
      $display("FAIL %s end: busy=%b level=%0d err=%b, expected busy=0 level=0 err=%b",
               name, busy, level, err, err_exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (btns !== '0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        level !== '0 || cmd_if.o_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: btns=%b done=%b err=%b busy=%b level=%0d ready=%b, expected 0 0 0 0 0 1",
               name, btns, done, err, busy, level, cmd_if.o_cmd_ready);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_held");
    rst = 1'b1;
    err_exp = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset_released");
  endtask

  task automatic test_single();
    tcmd_t q[$];
    q.push_back(mk(4, 10, 10, 5, 20));
    run_script("single", q);
  endtask

  task automatic test_back_to_back();
    tcmd_t q[$];
    q.push_back(mk(0, 0, 3, 0, 2));
    q.push_back(mk(1, 0, 1, 1, 1));
    run_script("back_to_back", q);
  endtask

  task automatic test_edge_fields();
    tcmd_t q[$];
    q.push_back(mk(2, 3, 5, 1, 0));
    q.push_back(mk(3, 0, 0, 2, 2));
    q.push_back(mk(1, 0, 0, 0, 0));
    q.push_back(mk(7, 2, 3, 1, 2));
    q.push_back(mk(0, 1, 0, 0, 3));
    run_script("edge_fields", q);
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      tcmd_t q[$];
      int    n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++)
        q.push_back(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3))));
      run_script($sformatf("random%0d", s), q);
    end
  endtask

  // A long blocker keeps the player busy while nine more commands arrive.
  task automatic test_fill();
    int dones = 0;
    bit multi = 1'b0;
    set_cmd(mk(0, 0, 200, 0, 1));
    tick();
    dones += int'(done);
    for (int k = 0; k < 9; k++) begin
      set_cmd(mk((k == 8) ? 3 : 1, 0, 1, 0, 1));
      tick();
      dones += int'(done);
      if ($countones(btns) > 1) multi = 1'b1;
      if (k == 7) begin
        n_tests++;
        if (cmd_if.o_cmd_ready !== 1'b0 || level !== 4'(DEPTH)) begin
          n_fail++;
          $display("FAIL fill_full: ready=%b level=%0d, expected ready=0 level=%0d",
                   cmd_if.o_cmd_ready, level, DEPTH);
        end
      end
    end
    drive_idle();
    n_tests++;
    if (level !== 4'(DEPTH)) begin
      n_fail++;
      $display("FAIL fill_ignored: level=%0d, expected %0d", level, DEPTH);
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      dones += int'(done);
      if ($countones(btns) > 1) multi = 1'b1;
    end
    n_tests++;
    if (dones != 9 || multi || busy !== 1'b0 || level !== '0) begin
      n_fail++;
      $display("FAIL fill_drain: done_pulses=%0d multi_hot=%b busy=%b level=%0d, expected 9 0 0 0",
               dones, multi, busy, level);
    end
  endtask

  task automatic test_reset_mid();
    tcmd_t q[$];
    bit    seen = 1'b0;
    set_cmd(mk(2, 0, 100, 0, 1));
    tick();
    set_cmd(mk(3, 0, 5, 0, 1));
    tick();
    drive_idle();
    for (int c = 0; c < 20 && !seen; c++) begin
      if (btns[2] === 1'b1) seen = 1'b1;
      else tick();
    end
    n_tests++;
    if (!seen || level !== 4'(1)) begin
      n_fail++;
      $display("FAIL reset_mid_setup: press_seen=%b level=%0d, expected 1 1", seen, level);
    end
    repeat (10) tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    q.push_back(mk(2, 1, 3, 2, 2));
    run_script("after_reset", q);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_edge_fields();
    test_random();
    test_fill();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
